bb_uart_frame_rx: RTL

- Receive side of the bus-bridge UART link, placed directly downstream of a demo instance's UART TX pin (m_u_tx or s_u_tx).
- Deserializes 8N1 bytes and assembles them into bus-bridge request frames (read/write, address, data).
- Presents each complete frame to the local bridge logic over a valid/ready handshake.
- Discards malformed frames, timed-out frames and frames that arrive while the output is still full, and flags each case.

---
 rtl/bb_uart_frame_rx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/bb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : bb_uart_frame_rx
// Brief    : 8N1 UART receiver that assembles bus-bridge request frames and
//            presents them on a valid/ready handshake with error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module bb_uart_frame_rx #(
    parameter int ADDR_WIDTH            = 16,
    parameter int DATA_WIDTH            = 8,
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int GAP_TIMEOUT_BITS      = 20
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  u_rx,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_write,
    output logic [ADDR_WIDTH-1:0] frame_addr,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  err_hdr,
    output logic                  err_frame,
    output logic                  err_timeout,
    output logic                  err_overflow
);

    localparam int c_na      = ADDR_WIDTH / 8;
    localparam int c_cnt_w   = $clog2(UART_CLOCKS_PER_PULSE);
    localparam int c_gap_max = GAP_TIMEOUT_BITS * UART_CLOCKS_PER_PULSE;
    localparam int c_gap_w   = $clog2(c_gap_max);
    localparam int c_idx_w   = (c_na > 1) ? $clog2(c_na) : 1;

    localparam logic [c_cnt_w-1:0] c_half_m1  = c_cnt_w'(UART_CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_m1  = c_cnt_w'(UART_CLOCKS_PER_PULSE - 1);
    localparam logic [c_gap_w-1:0] c_gap_m1   = c_gap_w'(c_gap_max - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_na - 1);
    localparam logic [7:0]         c_hdr_wr   = 8'hA5;
    localparam logic [7:0]         c_hdr_rd   = 8'h5A;

    localparam logic [2:0] c_bit_idle  = 3'd0;
    localparam logic [2:0] c_bit_start = 3'd1;
    localparam logic [2:0] c_bit_data  = 3'd2;
    localparam logic [2:0] c_bit_stop  = 3'd3;
    localparam logic [2:0] c_bit_brk   = 3'd4;

    localparam logic [1:0] c_frm_hdr  = 2'd0;
    localparam logic [1:0] c_frm_addr = 2'd1;
    localparam logic [1:0] c_frm_data = 2'd2;

    logic                  r_rx_meta, r_rxs;
    logic [2:0]            r_bit_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_byte_valid;
    logic                  r_err_frame;

    logic [1:0]            r_frm_state;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_req_write;
    logic [ADDR_WIDTH-1:0] r_addr_acc;
    logic [c_gap_w-1:0]    r_gap;
    logic                  r_frame_valid, r_frame_write;
    logic [ADDR_WIDTH-1:0] r_frame_addr;
    logic [DATA_WIDTH-1:0] r_frame_data;
    logic                  r_err_hdr, r_err_timeout, r_err_overflow;

    logic                  w_start_det;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_complete;

    assign w_start_det = (r_bit_state == c_bit_idle) && !r_rxs;
    assign w_addr_next = (r_addr_acc << 8) | ADDR_WIDTH'(r_shift);
    assign w_complete  = r_byte_valid &&
                         ((r_frm_state == c_frm_data) ||
                          (r_frm_state == c_frm_addr && r_idx == c_idx_last && !r_req_write));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= u_rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Bit-level receiver: samples mid-bit, LSB first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bit_state  <= c_bit_idle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_err_frame  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_err_frame  <= 1'b0;
            case (r_bit_state)
                c_bit_idle: begin
                    r_cnt <= '0;
                    if (!r_rxs) r_bit_state <= c_bit_start;
                end
                c_bit_start: begin
                    if (r_cnt == c_half_m1) begin
                        r_cnt       <= '0;
                        r_bit_idx   <= '0;
                        r_bit_state <= r_rxs ? c_bit_idle : c_bit_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_bit_data: begin
                    if (r_cnt == c_full_m1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_bit_state <= c_bit_stop;
                        else                   r_bit_idx   <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_bit_stop: begin
                    if (r_cnt == c_full_m1) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_byte_valid <= 1'b1;
                            r_bit_state  <= c_bit_idle;
                        end else begin
                            r_err_frame <= 1'b1;
                            r_bit_state <= c_bit_brk;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_bit_brk: begin
                    // Line held low after a bad stop bit; resync on the next high.
                    if (r_rxs) r_bit_state <= c_bit_idle;
                end
                default: r_bit_state <= c_bit_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frm_state    <= c_frm_hdr;
            r_idx          <= '0;
            r_req_write    <= 1'b0;
            r_addr_acc     <= '0;
            r_gap          <= '0;
            r_frame_valid  <= 1'b0;
            r_frame_write  <= 1'b0;
            r_frame_addr   <= '0;
            r_frame_data   <= '0;
            r_err_hdr      <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_hdr      <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overflow <= 1'b0;

            if (r_frame_valid && frame_ready) r_frame_valid <= 1'b0;

            // Acceptance on this edge frees the slot, so a coincident completion loads.
            if (w_complete) begin
                if (r_frame_valid && !frame_ready) begin
                    r_err_overflow <= 1'b1;
                end else begin
                    r_frame_valid <= 1'b1;
                    r_frame_write <= r_req_write;
                    r_frame_addr  <= (r_frm_state == c_frm_data) ? r_addr_acc : w_addr_next;
                    r_frame_data  <= (r_frm_state == c_frm_data) ? DATA_WIDTH'(r_shift) : '0;
                end
            end

            if (r_err_frame) begin
                r_frm_state <= c_frm_hdr;
                r_gap       <= '0;
            end else if (r_byte_valid) begin
                r_gap <= '0;
                case (r_frm_state)
                    c_frm_hdr: begin
                        r_idx      <= '0;
                        r_addr_acc <= '0;
                        if (r_shift == c_hdr_wr) begin
                            r_req_write <= 1'b1;
                            r_frm_state <= c_frm_addr;
                        end else if (r_shift == c_hdr_rd) begin
                            r_req_write <= 1'b0;
                            r_frm_state <= c_frm_addr;
                        end else begin
                            r_err_hdr <= 1'b1;
                        end
                    end
                    c_frm_addr: begin
                        r_addr_acc <= w_addr_next;
                        if (r_idx == c_idx_last)
                            r_frm_state <= r_req_write ? c_frm_data : c_frm_hdr;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                    default: r_frm_state <= c_frm_hdr;
                endcase
            end else if (r_frm_state != c_frm_hdr && r_bit_state == c_bit_idle && !w_start_det) begin
                if (r_gap == c_gap_m1) begin
                    r_err_timeout <= 1'b1;
                    r_frm_state   <= c_frm_hdr;
                    r_gap         <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end else begin
                r_gap <= '0;
            end
        end
    end

    assign frame_valid  = r_frame_valid;
    assign frame_write  = r_frame_write;
    assign frame_addr   = r_frame_addr;
    assign frame_data   = r_frame_data;
    assign err_hdr      = r_err_hdr;
    assign err_frame    = r_err_frame;
    assign err_timeout  = r_err_timeout;
    assign err_overflow = r_err_overflow;

endmodule
`default_nettype wire
